// File: rtl/axioma_io_master.sv
// I/O-bus initiator: turns IN/OUT/SBI/CBI/SBIS/SBIC micro-ops into single-cycle
// read/write strobes toward memory-mapped peripherals.
module axioma_io_master #(
    parameter logic [5:0] PINB_ADDR = 6'h23,
    parameter logic [5:0] PINC_ADDR = 6'h26,
    parameter logic [5:0] PIND_ADDR = 6'h29
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [5:0] req_addr,
    input  logic [2:0] req_bit,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_skip,
    output logic       rsp_err,
    output logic [5:0] io_addr,
    output logic [7:0] io_wdata,
    input  logic [7:0] io_rdata,
    output logic       io_read,
    output logic       io_write
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_IN   = 3'd0;
    localparam logic [2:0] OP_OUT  = 3'd1;
    localparam logic [2:0] OP_SBI  = 3'd2;
    localparam logic [2:0] OP_CBI  = 3'd3;
    localparam logic [2:0] OP_SBIS = 3'd4;
    localparam logic [2:0] OP_SBIC = 3'd5;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [5:0] addr_q, addr_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] wr_q, wr_d;
    logic [7:0] data_q, data_d;
    logic       skip_q, skip_d;
    logic       err_q, err_d;

    function automatic logic [7:0] bit_mask(input logic [2:0] b);
        return 8'h01 << b;
    endfunction

    // PINx registers toggle on write-1, so bit ops there skip the read phase.
    function automatic logic is_pin(input logic [5:0] a);
        return (a == PINB_ADDR) || (a == PINC_ADDR) || (a == PIND_ADDR);
    endfunction

    // State register and response/bus holding registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            addr_q  <= 6'd0;
            bit_q   <= 3'd0;
            wr_q    <= 8'd0;
            data_q  <= 8'd0;
            skip_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            bit_q   <= bit_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            skip_q  <= skip_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-value logic; bus write data is computed one cycle ahead.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        bit_d   = bit_q;
        wr_d    = wr_q;
        data_d  = data_q;
        skip_d  = skip_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    addr_d = req_addr;
                    bit_d  = req_bit;
                    skip_d = 1'b0;
                    err_d  = 1'b0;
                    case (req_op)
                        OP_IN, OP_SBIS, OP_SBIC: state_d = ST_READ;
                        OP_OUT: begin
                            state_d = ST_WRITE;
                            wr_d    = req_wdata;
                            data_d  = req_wdata;
                        end
                        OP_SBI, OP_CBI: begin
                            if (is_pin(req_addr)) begin
                                state_d = ST_WRITE;
                                wr_d    = (req_op == OP_SBI) ? bit_mask(req_bit) : 8'h00;
                                data_d  = (req_op == OP_SBI) ? bit_mask(req_bit) : 8'h00;
                            end else begin
                                state_d = ST_READ;
                            end
                        end
                        default: begin
                            state_d = ST_RESP;
                            err_d   = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                data_d = io_rdata;
                case (op_q)
                    OP_SBI: begin
                        state_d = ST_WRITE;
                        wr_d    = io_rdata | bit_mask(bit_q);
                    end
                    OP_CBI: begin
                        state_d = ST_WRITE;
                        wr_d    = io_rdata & ~bit_mask(bit_q);
                    end
                    OP_SBIS: begin
                        state_d = ST_RESP;
                        skip_d  = io_rdata[bit_q];
                    end
                    OP_SBIC: begin
                        state_d = ST_RESP;
                        skip_d  = ~io_rdata[bit_q];
                    end
                    default: state_d = ST_RESP;
                endcase
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign io_read   = (state_q == ST_READ);
    assign io_write  = (state_q == ST_WRITE);
    assign rsp_valid = (state_q == ST_RESP);
    assign io_addr   = addr_q;
    assign io_wdata  = wr_q;
    assign rsp_data  = data_q;
    assign rsp_skip  = skip_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_axioma_io_master.sv
// Self-checking bench for axioma_io_master: directed and random micro-ops
// compared against a behavioural model of the expected bus and response.
module tb_axioma_io_master;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_op = 3'd0;
    logic [5:0] req_addr = 6'd0;
    logic [2:0] req_bit = 3'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_skip;
    logic       rsp_err;
    logic [5:0] io_addr;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic       io_read;
    logic       io_write;

    logic [7:0] rdata_drv = 8'd0;
    assign io_rdata = rdata_drv;

    int total = 0;
    int bad = 0;
    logic [7:0] prev_data = 8'd0;

    int rd_cnt = 0;
    int wr_cnt = 0;
    int both_cnt = 0;
    logic [5:0] rd_addr_seen = 6'd0;
    logic [5:0] wr_addr_seen = 6'd0;
    logic [7:0] wr_data_seen = 8'd0;

    axioma_io_master dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_bit(req_bit), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_skip(rsp_skip), .rsp_err(rsp_err),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .io_read(io_read), .io_write(io_write)
    );

    always #5 clk = ~clk;

    // Bus monitor: tallies strobe cycles mid-cycle.
    always @(negedge clk) begin
        if (io_read === 1'b1) begin
            rd_cnt++;
            rd_addr_seen = io_addr;
        end
        if (io_write === 1'b1) begin
            wr_cnt++;
            wr_addr_seen = io_addr;
            wr_data_seen = io_wdata;
        end
        if (io_read === 1'b1 && io_write === 1'b1) both_cnt++;
    end

    function automatic bit pin_addr(input logic [5:0] a);
        return (a == 6'h23) || (a == 6'h26) || (a == 6'h29);
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [5:0] addr, input logic [2:0] b,
                          input logic [7:0] wd, input logic [7:0] rd, input int hold);
        int exp_rd, exp_wr, exp_lat, lat, rd0, wr0, both0;
        logic [7:0] exp_wv, exp_data, mask;
        logic exp_skip, exp_err;
        mask = 8'(1 << b);
        exp_rd = 0; exp_wr = 0; exp_wv = 8'd0; exp_skip = 1'b0; exp_err = 1'b0;
        exp_data = prev_data; exp_lat = 2;
        case (op)
            3'd0: begin exp_rd = 1; exp_data = rd; end
            3'd1: begin exp_wr = 1; exp_wv = wd; exp_data = wd; end
            3'd2, 3'd3: begin
                exp_wr = 1;
                if (pin_addr(addr)) begin
                    exp_wv = (op == 3'd2) ? mask : 8'd0;
                    exp_data = exp_wv;
                end else begin
                    exp_rd = 1; exp_lat = 3; exp_data = rd;
                    exp_wv = (op == 3'd2) ? (rd | mask) : (rd & ~mask);
                end
            end
            3'd4: begin exp_rd = 1; exp_data = rd; exp_skip = ((rd >> b) & 8'd1) == 8'd1; end
            3'd5: begin exp_rd = 1; exp_data = rd; exp_skip = ((rd >> b) & 8'd1) == 8'd0; end
            default: begin exp_err = 1'b1; exp_lat = 1; end
        endcase

        rdata_drv = rd;
        rsp_ready = (hold == 0);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_idle got=%b want=1", req_ready); end
        rd0 = rd_cnt; wr0 = wr_cnt; both0 = both_cnt;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_bit = b; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = ~wd;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat != exp_lat) begin bad++; $display("FAIL latency op=%0d got=%0d want=%0d", op, lat, exp_lat); end
        total++;
        if (rsp_data !== exp_data) begin bad++; $display("FAIL rsp_data op=%0d got=%h want=%h", op, rsp_data, exp_data); end
        total++;
        if (rsp_skip !== exp_skip) begin bad++; $display("FAIL rsp_skip op=%0d got=%b want=%b", op, rsp_skip, exp_skip); end
        total++;
        if (rsp_err !== exp_err) begin bad++; $display("FAIL rsp_err op=%0d got=%b want=%b", op, rsp_err, exp_err); end
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL ready_busy got=%b want=0", req_ready); end
        total++;
        if (rd_cnt - rd0 != exp_rd) begin bad++; $display("FAIL read_count op=%0d got=%0d want=%0d", op, rd_cnt - rd0, exp_rd); end
        total++;
        if (wr_cnt - wr0 != exp_wr) begin bad++; $display("FAIL write_count op=%0d got=%0d want=%0d", op, wr_cnt - wr0, exp_wr); end
        total++;
        if (both_cnt != both0) begin bad++; $display("FAIL strobe_overlap got=%0d want=%0d", both_cnt - both0, 0); end
        if (exp_wr == 1) begin
            total++;
            if (wr_addr_seen !== addr || wr_data_seen !== exp_wv) begin
                bad++;
                $display("FAIL write_beat op=%0d got=%h/%h want=%h/%h", op, wr_addr_seen, wr_data_seen, addr, exp_wv);
            end
        end
        if (exp_rd == 1) begin
            total++;
            if (rd_addr_seen !== addr) begin bad++; $display("FAIL read_addr got=%h want=%h", rd_addr_seen, addr); end
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_skip !== exp_skip
                || rsp_err !== exp_err || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL rsp_hold cyc=%0d got=%b/%h want=1/%h", i, rsp_valid, rsp_data, exp_data);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rsp_release got=%b/%b want=0/1", rsp_valid, req_ready);
        end
        prev_data = exp_data;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_skip !== 1'b0 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b%b%b%b want=1000", req_ready, rsp_valid, rsp_skip, rsp_err);
        end
        total++;
        if (rsp_data !== 8'h00 || io_addr !== 6'h00 || io_wdata !== 8'h00 || io_read !== 1'b0 || io_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h/%h/%b%b want=00/00/00/00", rsp_data, io_addr, io_wdata, io_read, io_write);
        end
        reset_n = 1'b1;
        prev_data = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(3'd1, 6'h25, 3'd0, 8'hA5, 8'h00, 0);
        run_op(3'd0, 6'h24, 3'd0, 8'h00, 8'h3C, 0);
        run_op(3'd2, 6'h25, 3'd7, 8'h00, 8'h01, 0);
        run_op(3'd3, 6'h25, 3'd0, 8'h00, 8'h81, 0);
        run_op(3'd2, 6'h23, 3'd2, 8'h00, 8'hFF, 0);
        run_op(3'd3, 6'h29, 3'd5, 8'h00, 8'hFF, 0);
        run_op(3'd4, 6'h3F, 3'd3, 8'h00, 8'h08, 0);
        run_op(3'd5, 6'h3F, 3'd3, 8'h00, 8'h08, 0);
        run_op(3'd7, 6'h10, 3'd1, 8'h55, 8'h00, 0);
        run_op(3'd6, 6'h11, 3'd1, 8'h55, 8'h00, 0);
    endtask

    task automatic test_back_pressure();
        run_op(3'd0, 6'h26, 3'd0, 8'h00, 8'h96, 5);
        run_op(3'd2, 6'h3F, 3'd7, 8'h00, 8'h7E, 3);
    endtask

    task automatic test_random();
        logic [5:0] a;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: a = 6'h23;
                1: a = ($urandom_range(0, 1) == 0) ? 6'h26 : 6'h29;
                default: a = 6'($urandom);
            endcase
            run_op(3'($urandom), a, 3'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid_op();
        int w0;
        rdata_drv = 8'h12;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 3'd2; req_addr = 6'h25; req_bit = 3'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++;
        if (io_read !== 1'b1) begin bad++; $display("FAIL midreset_read got=%b want=1", io_read); end
        w0 = wr_cnt;
        reset_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if (req_ready !== 1'b1 || io_read !== 1'b0 || io_write !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle got=%b%b%b%b want=1000", req_ready, io_read, io_write, rsp_valid);
        end
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (wr_cnt != w0) begin bad++; $display("FAIL midreset_nowrite got=%0d want=%0d", wr_cnt - w0, 0); end
        prev_data = 8'h00;
        run_op(3'd0, 6'h01, 3'd0, 8'h00, 8'hC3, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_pressure();
        test_random();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
